// File: rtl/weighted_round_robin.sv
// Weighted round-robin scheduler: walks a programmable slot table and forwards
// the pop word of the channel owning each slot, or zero if that channel is empty.
module weighted_round_robin #(
  parameter int unsigned NUM_SLOTS = 64,
  parameter int unsigned DATA_W    = 4
) (
  input  logic                   clk0,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   init,
  input  logic [2*NUM_SLOTS-1:0] tester_input,
  input  logic [DATA_W-1:0]      pop_vchannel0,
  input  logic [DATA_W-1:0]      pop_vchannel1,
  input  logic [DATA_W-1:0]      pop_vchannel2,
  input  logic [DATA_W-1:0]      pop_vchannel3,
  input  logic                   empty_vchannel0,
  input  logic                   empty_vchannel1,
  input  logic                   empty_vchannel2,
  input  logic                   empty_vchannel3,
  output logic [DATA_W-1:0]      wghtd_output
);

  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [1:0]        tbl [NUM_SLOTS];
  logic [1:0]        ch_c;
  logic [DATA_W-1:0] pop_sel_c;
  logic              empty_sel_c;

  // Channel owning the current slot and its FIFO status
  always_comb begin
    ch_c        = tbl[ptr];
    pop_sel_c   = '0;
    empty_sel_c = 1'b1;
    case (ch_c)
      2'd0: begin pop_sel_c = pop_vchannel0; empty_sel_c = empty_vchannel0; end
      2'd1: begin pop_sel_c = pop_vchannel1; empty_sel_c = empty_vchannel1; end
      2'd2: begin pop_sel_c = pop_vchannel2; empty_sel_c = empty_vchannel2; end
      default: begin pop_sel_c = pop_vchannel3; empty_sel_c = empty_vchannel3; end
    endcase
  end

  // Table load takes precedence over service; an empty slot is still consumed
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      wghtd_output <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) tbl[k] <= 2'(k);
    end else if (init) begin
      ptr          <= '0;
      wghtd_output <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) tbl[k] <= tester_input[2*k +: 2];
    end else if (enb) begin
      wghtd_output <= empty_sel_c ? '0 : pop_sel_c;
      ptr          <= (ptr == PTR_W'(NUM_SLOTS - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_weighted_round_robin.sv
// Directed bench for weighted_round_robin with hand-computed output sequences.
module tb_weighted_round_robin;

  localparam logic [3:0] PA = 4'hA;
  localparam logic [3:0] PB = 4'hB;
  localparam logic [3:0] PC = 4'hC;
  localparam logic [3:0] PD = 4'hD;

  logic         clk0 = 1'b0;
  logic         rst;
  logic         enb;
  logic         init;
  logic [127:0] tester_input;
  logic [3:0]   pop0, pop1, pop2, pop3;
  logic         emp0, emp1, emp2, emp3;
  logic [3:0]   wghtd_output;

  int errors = 0;
  int checks = 0;

  weighted_round_robin dut (
    .clk0            (clk0),
    .rst             (rst),
    .enb             (enb),
    .init            (init),
    .tester_input    (tester_input),
    .pop_vchannel0   (pop0),
    .pop_vchannel1   (pop1),
    .pop_vchannel2   (pop2),
    .pop_vchannel3   (pop3),
    .empty_vchannel0 (emp0),
    .empty_vchannel1 (emp1),
    .empty_vchannel2 (emp2),
    .empty_vchannel3 (emp3),
    .wghtd_output    (wghtd_output)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_seq [8];
    logic [1:0] load4 [4];

    rst = 1'b0; enb = 1'b0; init = 1'b0; tester_input = '0;
    pop0 = PA; pop1 = PB; pop2 = PC; pop3 = PD;
    emp0 = 1'b0; emp1 = 1'b0; emp2 = 1'b0; emp3 = 1'b0;

    tick();
    check("reset_out", wghtd_output, 4'h0);
    rst = 1'b1;
    enb = 1'b1;

    // Default table: plain round robin from slot 0
    exp_seq = '{PA, PB, PC, PD, PA, PB, PC, PD};
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("default_%0d", i), wghtd_output, exp_seq[i]);
    end

    // Channel 1 empty: its slots yield zero but are consumed
    emp1 = 1'b1;
    exp_seq = '{PA, 4'h0, PC, PD, PA, 4'h0, PC, PD};
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("empty1_%0d", i), wghtd_output, exp_seq[i]);
    end
    emp1 = 1'b0;

    // Freeze: serve slots 16,17, hold for 5 cycles, resume at slot 18
    tick(); check("pre_freeze_0", wghtd_output, PA);
    tick(); check("pre_freeze_1", wghtd_output, PB);
    enb  = 1'b0;
    pop1 = 4'h5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("freeze_%0d", i), wghtd_output, PB);
    end
    pop1 = PB;
    enb  = 1'b1;
    tick(); check("resume_0", wghtd_output, PC);
    tick(); check("resume_1", wghtd_output, PD);

    // Load slots 0..3 = 2,0,1,2, rest = 3, with init and enb on the same edge
    load4 = '{2'd2, 2'd0, 2'd1, 2'd2};
    for (int k = 0; k < 64; k++) tester_input[2*k +: 2] = (k < 4) ? load4[k] : 2'd3;
    init = 1'b1;
    tick();
    check("load_edge", wghtd_output, 4'h0);
    init = 1'b0;
    tester_input = '0;
    exp_seq = '{PC, PA, PB, PC, PD, PD, PD, PD};
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("loaded_%0d", i), wghtd_output, exp_seq[i]);
    end

    // Load with enb low: all ch3 except slot 63 = ch0
    enb = 1'b0;
    for (int k = 0; k < 64; k++) tester_input[2*k +: 2] = (k == 63) ? 2'd0 : 2'd3;
    init = 1'b1;
    tick();
    check("load_noenb_edge", wghtd_output, 4'h0);
    init = 1'b0;
    enb  = 1'b1;
    for (int i = 0; i < 130; i++) begin
      tick();
      check($sformatf("wrap_%0d", i), wghtd_output, ((i % 64) == 63) ? PA : PD);
    end

    // Async reset between edges clears output at once and restores default table
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_now", wghtd_output, 4'h0);
    tick();
    check("async_rst_hold", wghtd_output, 4'h0);
    rst = 1'b1;
    exp_seq = '{PA, PB, PC, PD, PA, PB, PC, PD};
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst_%0d", i), wghtd_output, exp_seq[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
